// File: rtl/alu_writeback.sv
// Write-back stage after the ALU: retires one 32-bit result per op into a
// 16-bit register file (one or two words) and optionally latches ALU flags.
module alu_writeback #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   alu_result,
    input  logic                  alu_za,
    input  logic                  alu_zb,
    input  logic                  alu_eq,
    input  logic                  alu_gt,
    input  logic                  alu_lt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  wide,
    input  logic                  flag_en,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [4:0]            status,
    output logic                  done
);

    localparam int RES_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [RES_W-1:0]        res_q, res_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic                    wide_q, wide_d;
    logic [4:0]              status_q, status_d;
    logic                    accept;

    // A wide op blocks acceptance only while its low word is being written.
    assign in_ready = (state_q == IDLE) || (state_q == WR_LO && !wide_q) || (state_q == WR_HI);
    assign accept   = in_valid && in_ready;
    assign status   = status_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = IDLE;
        res_d    = res_q;
        rd_d     = rd_q;
        wide_d   = wide_q;
        status_d = status_q;

        if (accept) begin
            state_d = WR_LO;
            res_d   = alu_result;
            rd_d    = rd;
            wide_d  = wide;
            if (flag_en) begin
                status_d = {alu_za, alu_zb, alu_eq, alu_gt, alu_lt};
            end
        end else if (state_q == WR_LO && wide_q) begin
            state_d = WR_HI;
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        done     = 1'b0;
        case (state_q)
            WR_LO: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = res_q[DATA_W-1:0];
                done     = !wide_q;
            end
            WR_HI: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q + REG_ADDR_W'(1);   // wraps past the last register
                rf_wdata = res_q[RES_W-1:DATA_W];
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            res_q    <= '0;
            rd_q     <= '0;
            wide_q   <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            rd_q     <= rd_d;
            wide_q   <= wide_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed cycle table, then random ops checked
// against a queue-based model of the pending register-file writes.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_za, alu_zb, alu_eq, alu_gt, alu_lt;
    logic [2:0]  rd;
    logic        wide;
    logic        flag_en;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [4:0]  status;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_writeback #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .alu_za     (alu_za),
        .alu_zb     (alu_zb),
        .alu_eq     (alu_eq),
        .alu_gt     (alu_gt),
        .alu_lt     (alu_lt),
        .rd         (rd),
        .wide       (wide),
        .flag_en    (flag_en),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .status     (status),
        .done       (done)
    );

    // One row = inputs applied this cycle + outputs expected this cycle.
    typedef struct {
        logic        rst;
        logic        valid;
        logic [2:0]  rd;
        logic [31:0] res;
        logic        wide;
        logic        fen;
        logic [4:0]  flags;
        logic        chk;
        logic        e_ready;
        logic        e_we;
        logic [2:0]  e_addr;
        logic [15:0] e_data;
        logic        e_done;
        logic [4:0]  e_status;
    } vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        last;
    } wr_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic r, input logic v, input logic [2:0] a,
                                input logic [31:0] res, input logic w, input logic f,
                                input logic [4:0] fl, input logic c, input logic e_rdy,
                                input logic e_we, input logic [2:0] e_a,
                                input logic [15:0] e_d, input logic e_dn,
                                input logic [4:0] e_st);
        vec_t x;
        x.rst = r; x.valid = v; x.rd = a; x.res = res; x.wide = w; x.fen = f;
        x.flags = fl; x.chk = c; x.e_ready = e_rdy; x.e_we = e_we; x.e_addr = e_a;
        x.e_data = e_d; x.e_done = e_dn; x.e_status = e_st;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_rdy, input logic e_we,
                                 input logic [2:0] e_a, input logic [15:0] e_d,
                                 input logic e_dn, input logic [4:0] e_st);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
        check({tag, ".rf_we"},    32'(rf_we),    32'(e_we));
        check({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(e_a));
        check({tag, ".rf_wdata"}, 32'(rf_wdata), 32'(e_d));
        check({tag, ".done"},     32'(done),     32'(e_dn));
        check({tag, ".status"},   32'(status),   32'(e_st));
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] a,
                         input logic [31:0] res, input logic w, input logic f,
                         input logic [4:0] fl);
        rst = r; in_valid = v; rd = a; alu_result = res; wide = w; flag_en = f;
        {alu_za, alu_zb, alu_eq, alu_gt, alu_lt} = fl;
    endtask

    initial begin
        wr_t         pend[$];
        wr_t         cur;
        logic [4:0]  st_model;
        logic        holding;
        logic        m_ready;
        logic        op_wide, op_fen, op_valid;
        logic [2:0]  op_rd;
        logic [31:0] op_res;
        logic [4:0]  op_flags;

        drive(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 5'd0);

        //            rst v  rd    result         wide fen flags     chk rdy we addr  data      done status
        vecs[0]  = mk(1, 0, 3'd0, 32'h0,          0, 0, 5'b00000, 0,  0,  0, 3'd0, 16'h0000, 0, 5'b00000);
        vecs[1]  = mk(0, 1, 3'd3, 32'h0000_0011,  0, 0, 5'b00000, 1,  1,  0, 3'd0, 16'h0000, 0, 5'b00000);
        vecs[2]  = mk(0, 0, 3'd0, 32'h0,          0, 0, 5'b00000, 1,  1,  1, 3'd3, 16'h0011, 1, 5'b00000);
        vecs[3]  = mk(0, 1, 3'd2, 32'h0001_2345,  1, 0, 5'b00000, 1,  1,  0, 3'd0, 16'h0000, 0, 5'b00000);
        vecs[4]  = mk(0, 1, 3'd7, 32'hABCD_1234,  1, 0, 5'b00000, 1,  0,  1, 3'd2, 16'h2345, 0, 5'b00000);
        vecs[5]  = mk(0, 1, 3'd7, 32'hABCD_1234,  1, 0, 5'b00000, 1,  1,  1, 3'd3, 16'h0001, 1, 5'b00000);
        vecs[6]  = mk(0, 0, 3'd0, 32'h0,          0, 0, 5'b00000, 1,  0,  1, 3'd7, 16'h1234, 0, 5'b00000);
        vecs[7]  = mk(0, 1, 3'd1, 32'h0000_000A,  0, 0, 5'b00000, 1,  1,  1, 3'd0, 16'hABCD, 1, 5'b00000);
        vecs[8]  = mk(0, 1, 3'd2, 32'hFFFF_000B,  0, 0, 5'b00000, 1,  1,  1, 3'd1, 16'h000A, 1, 5'b00000);
        vecs[9]  = mk(0, 1, 3'd3, 32'h0000_000C,  0, 0, 5'b00000, 1,  1,  1, 3'd2, 16'h000B, 1, 5'b00000);
        vecs[10] = mk(0, 0, 3'd0, 32'h0,          0, 0, 5'b00000, 1,  1,  1, 3'd3, 16'h000C, 1, 5'b00000);
        vecs[11] = mk(0, 1, 3'd0, 32'h0000_0001,  0, 1, 5'b00100, 1,  1,  0, 3'd0, 16'h0000, 0, 5'b00000);
        vecs[12] = mk(0, 1, 3'd1, 32'h0,          0, 0, 5'b00010, 1,  1,  1, 3'd0, 16'h0001, 1, 5'b00100);
        vecs[13] = mk(0, 1, 3'd2, 32'h0000_0005,  0, 1, 5'b11000, 1,  1,  1, 3'd1, 16'h0000, 1, 5'b00100);
        vecs[14] = mk(0, 1, 3'd5, 32'h1234_5678,  1, 1, 5'b00001, 1,  1,  1, 3'd2, 16'h0005, 1, 5'b11000);
        vecs[15] = mk(1, 0, 3'd0, 32'h0,          0, 0, 5'b00000, 1,  0,  1, 3'd5, 16'h5678, 0, 5'b00001);
        vecs[16] = mk(0, 0, 3'd0, 32'h0,          0, 0, 5'b00000, 1,  1,  0, 3'd0, 16'h0000, 0, 5'b00000);
        vecs[17] = mk(0, 0, 3'd0, 32'h0,          0, 0, 5'b00000, 1,  1,  0, 3'd0, 16'h0000, 0, 5'b00000);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (vecs[i].chk) begin
                check_outputs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_we,
                              vecs[i].e_addr, vecs[i].e_data, vecs[i].e_done, vecs[i].e_status);
            end
            drive(vecs[i].rst, vecs[i].valid, vecs[i].rd, vecs[i].res,
                  vecs[i].wide, vecs[i].fen, vecs[i].flags);
        end

        // Random phase: the DUT is idle with cleared status after the reset rows.
        st_model = 5'b00000;
        holding  = 1'b0;
        op_valid = 1'b0;
        op_rd = '0; op_res = '0; op_wide = 1'b0; op_fen = 1'b0; op_flags = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (pend.size() > 0) begin
                cur = pend.pop_front();
                m_ready = (pend.size() == 0);
                check_outputs("rnd", m_ready, 1'b1, cur.addr, cur.data, cur.last, st_model);
            end else begin
                m_ready = 1'b1;
                check_outputs("rnd", 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, st_model);
            end

            if (!holding) begin
                op_valid = ($urandom_range(0, 3) != 0);
                op_rd    = 3'($urandom_range(0, 7));
                op_res   = $urandom;
                op_wide  = 1'($urandom_range(0, 1));
                op_fen   = 1'($urandom_range(0, 1));
                op_flags = 5'($urandom_range(0, 31));
            end
            drive(1'b0, op_valid, op_rd, op_res, op_wide, op_fen, op_flags);

            if (op_valid && m_ready) begin
                holding = 1'b0;
                if (op_wide) begin
                    pend.push_back('{addr: op_rd, data: op_res[15:0], last: 1'b0});
                    pend.push_back('{addr: 3'((op_rd + 1) % 8), data: op_res[31:16], last: 1'b1});
                end else begin
                    pend.push_back('{addr: op_rd, data: op_res[15:0], last: 1'b1});
                end
                if (op_fen) st_model = op_flags;
            end else begin
                holding = op_valid;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
